spi_req_bridge: RTL and testbench

//   Sits between spi_slave (SPI-clock-derived re/we/addr/wdat) and the clk-domain

---
 rtl/spi_pkg.sv | 17 +
 rtl/sync_edge.sv | 27 ++
 rtl/spi_req_bridge.sv | 137 +++++++++++++
 tb/tb_spi_req_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-register-bank request path.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 96;

    localparam logic [AW_DEF-1:0] REG_GEN    = 7'h7D;
    localparam logic [AW_DEF-1:0] REG_RD_CNT = 7'h7E;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop level synchroniser followed by a registered rising-edge detector.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // prev starts at 0, so a level already high out of reset still yields one edge
    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/spi_req_bridge.sv
// Turns spi_slave re/we levels into single-cycle register-bank strobes and
// returns read data with a bounded wait, counting timeouts and dropped reads.
module spi_req_bridge
    import spi_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_re,
    input  logic          spi_we,
    input  logic [AW-1:0] spi_addr,
    input  logic [DW-1:0] spi_wdat,
    output logic [DW-1:0] spi_rdat,
    output logic          reg_wr_stb,
    output logic          reg_rd_stb,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdat,
    input  logic [DW-1:0] reg_rdat,
    input  logic          reg_rd_valid,
    output logic          busy,
    output logic [7:0]    err_timeout,
    output logic [7:0]    err_overrun
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    state_t        state_reg;
    logic          pending_wr_reg;
    logic          pending_rd_reg;
    logic [TW-1:0] tmo_reg;
    logic          re_rise;
    logic          we_rise;
    logic          rd_active;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_re (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_re),
        .rise    (re_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_we),
        .rise    (we_rise)
    );

    assign rd_active = (state_reg == RD) || (state_reg == WAIT);
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            pending_wr_reg <= 1'b0;
            pending_rd_reg <= 1'b0;
            tmo_reg        <= '0;
            reg_wr_stb     <= 1'b0;
            reg_rd_stb     <= 1'b0;
            reg_addr       <= '0;
            reg_wdat       <= '0;
            spi_rdat       <= '0;
            err_timeout    <= '0;
            err_overrun    <= '0;
        end else begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;

            // A repeated write edge collapses into the one already pending
            if (we_rise && !pending_wr_reg) begin
                pending_wr_reg <= 1'b1;
            end

            if (re_rise) begin
                if (pending_rd_reg || rd_active) begin
                    if (err_overrun != 8'hFF) begin
                        err_overrun <= err_overrun + 8'd1;
                    end
                end else begin
                    pending_rd_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    // Writes take priority so a simultaneous re/we pair is served write-first
                    if (pending_wr_reg) begin
                        state_reg      <= WR;
                        reg_wr_stb     <= 1'b1;
                        reg_addr       <= spi_addr;
                        reg_wdat       <= spi_wdat;
                        pending_wr_reg <= 1'b0;
                    end else if (pending_rd_reg) begin
                        state_reg      <= RD;
                        reg_rd_stb     <= 1'b1;
                        reg_addr       <= spi_addr;
                        pending_rd_reg <= 1'b0;
                        tmo_reg        <= TW'(RD_TIMEOUT);
                    end
                end
                WR: begin
                    state_reg <= IDLE;
                end
                RD: begin
                    if (reg_rd_valid) begin
                        spi_rdat  <= reg_rdat;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (reg_rd_valid) begin
                        spi_rdat  <= reg_rdat;
                        state_reg <= IDLE;
                    end else if (tmo_reg == TW'(1)) begin
                        spi_rdat  <= '0;
                        state_reg <= IDLE;
                        if (err_timeout != 8'hFF) begin
                            err_timeout <= err_timeout + 8'd1;
                        end
                    end else begin
                        tmo_reg <= tmo_reg - TW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_bridge.sv
// Scoreboard bench for spi_req_bridge: stimulus queues expected strobes,
// a register-bank responder answers reads, and a monitor checks every strobe.
module tb_spi_req_bridge;

    localparam int DW         = 96;
    localparam int AW         = 7;
    localparam int RD_TIMEOUT = 4;
    localparam int NEVER      = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_re = 1'b0;
    logic          spi_we = 1'b0;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_wdat = '0;
    logic [DW-1:0] spi_rdat;
    logic          reg_wr_stb;
    logic          reg_rd_stb;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdat;
    logic [DW-1:0] reg_rdat = '0;
    logic          reg_rd_valid = 1'b0;
    logic          busy;
    logic [7:0]    err_timeout;
    logic [7:0]    err_overrun;

    spi_req_bridge #(
        .DW(DW), .AW(AW), .SYNC_STAGES(2), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_re       (spi_re),
        .spi_we       (spi_we),
        .spi_addr     (spi_addr),
        .spi_wdat     (spi_wdat),
        .spi_rdat     (spi_rdat),
        .reg_wr_stb   (reg_wr_stb),
        .reg_rd_stb   (reg_rd_stb),
        .reg_addr     (reg_addr),
        .reg_wdat     (reg_wdat),
        .reg_rdat     (reg_rdat),
        .reg_rd_valid (reg_rd_valid),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        int            cyc;
        logic [DW-1:0] rdat;
        int            done;
    } exp_t;

    typedef struct {
        int            dly;
        logic [DW-1:0] rdat;
    } rsp_t;

    exp_t          sb_q[$];
    rsp_t          rsp_q[$];
    exp_t          mon_e;
    rsp_t          rsp_e;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            exp_tmo = 0;
    int            exp_ovr = 0;
    bit            rd_outstanding = 1'b0;
    logic [DW-1:0] rd_exp = '0;
    int            rd_done_exp = 0;
    int            rd_wait = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per strobe, then tracks the read to completion
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_outstanding = 1'b0;
        end else if (reg_wr_stb || reg_rd_stb) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got wr=%0b rd=%0b expected none (cycle %0d)",
                         reg_wr_stb, reg_rd_stb, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe_kind", DW'(reg_wr_stb), DW'(mon_e.is_wr));
                chk("strobe_cycle", DW'(cyc), DW'(mon_e.cyc));
                chk("reg_addr", DW'(reg_addr), DW'(mon_e.addr));
                if (mon_e.is_wr) begin
                    chk("reg_wdat", reg_wdat, mon_e.wdat);
                    $display("cycle %0d: WR addr=%0h wdat=%0h", cyc, reg_addr, reg_wdat);
                end else begin
                    rd_outstanding = 1'b1;
                    rd_exp         = mon_e.rdat;
                    rd_done_exp    = mon_e.done;
                    rd_wait        = 0;
                    $display("cycle %0d: RD addr=%0h expect rdat=%0h", cyc, reg_addr, mon_e.rdat);
                end
            end
        end else if (rd_outstanding) begin
            rd_wait++;
            if (!busy) begin
                chk("spi_rdat", spi_rdat, rd_exp);
                chk("read_duration", DW'(rd_wait), DW'(rd_done_exp));
                rd_outstanding = 1'b0;
            end else if (rd_wait > RD_TIMEOUT + 6) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_completion: busy still %0b after %0d cycles, required 0",
                         busy, rd_wait);
                rd_outstanding = 1'b0;
            end
        end
    end

    // Register-bank responder: answers each read strobe after a chosen delay
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && reg_rd_stb && rsp_q.size() != 0) begin
                rsp_e = rsp_q.pop_front();
                if (rsp_e.dly <= RD_TIMEOUT) begin
                    repeat (rsp_e.dly) @(negedge clk);
                    reg_rd_valid = 1'b1;
                    reg_rdat     = rsp_e.rdat;
                    @(negedge clk);
                    reg_rd_valid = 1'b0;
                    reg_rdat     = {$urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rd_outstanding && !busy) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: %0d strobes outstanding, busy=%0b, required idle", sb_q.size(), busy);
    endtask

    // Called on a negedge with the bridge idle; the first posedge after this samples the level
    task automatic do_xfer(input bit wr, input bit rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] rv);
        logic [DW-1:0] rexp;
        int            done;
        int            rcyc;
        rexp = (dly <= RD_TIMEOUT) ? rv : '0;
        done = (dly <= RD_TIMEOUT) ? dly + 1 : RD_TIMEOUT + 1;
        rcyc = wr ? cyc + 6 : cyc + 4;
        spi_addr = a;
        spi_wdat = wd;
        if (wr) sb_q.push_back('{1'b1, a, wd, cyc + 4, '0, 0});
        if (rd) begin
            sb_q.push_back('{1'b0, a, '0, rcyc, rexp, done});
            rsp_q.push_back('{dly, rv});
            if (dly > RD_TIMEOUT && exp_tmo < 255) exp_tmo++;
        end
        spi_we = wr;
        spi_re = rd;
        wait_idle();
        spi_we = 1'b0;
        spi_re = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_err_timeout"}, DW'(err_timeout), DW'(exp_tmo));
        chk({tag, "_err_overrun"}, DW'(err_overrun), DW'(exp_ovr));
    endtask

    initial begin
        logic [DW-1:0] v;
        int            kind;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_wr_stb", DW'(reg_wr_stb), '0);
        chk("rst_rd_stb", DW'(reg_rd_stb), '0);
        chk("rst_reg_addr", DW'(reg_addr), '0);
        chk("rst_reg_wdat", reg_wdat, '0);
        chk("rst_spi_rdat", spi_rdat, '0);
        chk_counters("rst");

        // 1: single write
        do_xfer(1'b1, 1'b0, 7'h7D, 96'd25000, 0, '0);
        // 2: read answered in the strobe cycle
        do_xfer(1'b0, 1'b1, 7'h7E, '0, 0, 96'd5);
        // 3: simultaneous edges, write first
        do_xfer(1'b1, 1'b1, 7'h12, 96'hABCD_0000_1234, 0, 96'h77);
        chk_counters("simul");

        // 4: reads that never see valid
        do_xfer(1'b0, 1'b1, 7'h7E, '0, NEVER, 96'h99);
        chk("tmo_first", DW'(err_timeout), DW'(1));
        for (int i = 1; i < 300; i++) do_xfer(1'b0, 1'b1, 7'h7E, '0, NEVER, 96'h99);
        chk("tmo_saturated", DW'(err_timeout), DW'(255));
        chk_counters("tmo");

        // 5: second read edge arrives while the first is in flight
        v = 96'hFEED_BEEF;
        spi_addr = 7'h21;
        sb_q.push_back('{1'b0, 7'h21, '0, cyc + 4, v, 4});
        rsp_q.push_back('{3, v});
        spi_re = 1'b1;
        @(negedge clk);
        spi_re = 1'b0;
        @(negedge clk);
        spi_re = 1'b1;
        exp_ovr++;
        wait_idle();
        spi_re = 1'b0;
        repeat (4) @(negedge clk);
        chk_counters("overrun");

        // 6: reset while waiting for read data, with spi_re held high across release
        spi_addr = 7'h7E;
        sb_q.push_back('{1'b0, 7'h7E, '0, cyc + 4, '0, 0});
        rsp_q.push_back('{NEVER, '0});
        spi_re = 1'b1;
        repeat (6) @(negedge clk);
        chk("busy_in_wait", DW'(busy), DW'(1));
        reset_n = 1'b0;
        @(negedge clk);
        exp_tmo = 0;
        exp_ovr = 0;
        chk("midrst_busy", DW'(busy), '0);
        chk("midrst_spi_rdat", spi_rdat, '0);
        chk("midrst_reg_addr", DW'(reg_addr), '0);
        chk_counters("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        v = 96'h5A5A;
        sb_q.push_back('{1'b0, 7'h7E, '0, cyc + 4, v, 1});
        rsp_q.push_back('{0, v});
        wait_idle();
        spi_re = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_reset_strobes_left", DW'(sb_q.size()), '0);

        // Randomised mix of writes, reads and simultaneous pairs
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            do_xfer(kind != 1, kind != 0, 7'($urandom), {$urandom, $urandom, $urandom},
                    $urandom_range(0, 6), {$urandom, $urandom, $urandom});
        end
        chk_counters("final");
        chk("queue_empty", DW'(sb_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
